// File: rtl/mem_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and load/store.
// One transaction in flight; illegal accesses and hung accesses return an error.
module mem_arbiter #(
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [2:0]  ls_op,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
    localparam bit TO_EN = (TIMEOUT != 0);

    state_t        state_q;
    state_t        state_d;
    logic          owner_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [2:0]    op_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [SW-1:0] starve_q;
    logic [TW-1:0] tcnt_q;

    logic          pick_if;
    logic          pick_ls;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [2:0]    req_op;
    logic [31:0]   req_wdata;
    logic          legal;
    logic          expire;

    always_comb begin
        pick_if = 1'b0;
        pick_ls = 1'b0;
        if (state_q == IDLE) begin
            pick_if = if_req && (!ls_req || starve_q == S_MAX);
            pick_ls = ls_req && !pick_if;
        end
    end

    assign req_we    = pick_if ? 1'b0 : ls_we;
    assign req_addr  = pick_if ? if_addr : ls_addr;
    assign req_op    = pick_if ? 3'b010 : ls_op;
    assign req_wdata = pick_if ? 32'd0 : ls_wdata;

    // Checked on the request being granted, i.e. exactly what gets latched.
    always_comb begin
        legal = 1'b0;
        unique case (req_op)
            3'b000:  legal = 1'b1;
            3'b001:  legal = (req_addr[1:0] != 2'b11);
            3'b010:  legal = (req_addr[1:0] == 2'b00);
            3'b100:  legal = !req_we;
            3'b101:  legal = !req_we && (req_addr[1:0] != 2'b11);
            default: legal = 1'b0;
        endcase
    end

    assign expire = TO_EN && (tcnt_q == T_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pick_if || pick_ls)
                    state_d = legal ? WAIT : RESP;
            end
            WAIT: begin
                if (mem_ack || expire)
                    state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            op_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
            tcnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_if || pick_ls) begin
                        owner_q <= pick_if;
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        op_q    <= req_op;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= !legal;
                    end
                    if (pick_if)
                        starve_q <= '0;
                    else if (pick_ls && if_req && starve_q != S_MAX)
                        starve_q <= starve_q + 1'b1;
                end
                WAIT: begin
                    tcnt_q <= tcnt_q + 1'b1;
                    // An ack in the expiry cycle still completes normally.
                    if (mem_ack) begin
                        rdata_q <= we_q ? 32'd0 : mem_rdata;
                        err_q   <= 1'b0;
                        tcnt_q  <= '0;
                    end else if (expire) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        tcnt_q  <= '0;
                    end
                end
                default: tcnt_q <= '0;
            endcase
        end
    end

    assign if_gnt = pick_if;
    assign ls_gnt = pick_ls;

    assign mem_req   = (state_q == WAIT);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q : 32'd0;
    assign mem_op    = mem_req ? op_q : 3'd0;
    assign mem_wdata = mem_req ? wdata_q : 32'd0;

    assign if_rvalid = (state_q == RESP) && owner_q;
    assign ls_rvalid = (state_q == RESP) && !owner_q;
    assign if_rdata  = if_rvalid ? rdata_q : 32'd0;
    assign ls_rdata  = ls_rvalid ? rdata_q : 32'd0;
    assign if_err    = if_rvalid && err_q;
    assign ls_err    = ls_rvalid && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random and directed bench for mem_arbiter against a transaction-level model.
// Model: winner/starvation as integers, legality from the access rules.
module tb_mem_arbiter;

    localparam int TO = 8;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [2:0]  ls_op = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_op;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int starve = 0;

    mem_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_op(ls_op), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_op(mem_op), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(bit we, logic [31:0] a, logic [2:0] op);
        int lo;
        lo = int'(a[1:0]);
        case (op)
            3'd0:    return 1'b1;
            3'd1:    return lo != 3;
            3'd2:    return lo == 0;
            3'd4:    return !we;
            3'd5:    return !we && lo != 3;
            default: return 1'b0;
        endcase
    endfunction

    // Entered at posedge+1 in IDLE with at least one request driven.
    // d = WAIT cycle carrying mem_ack (1..TO), 0 = never ack.
    task automatic run_txn(input int d, input logic [31:0] rd,
                           output bit won_if);
        bit          wi;
        bit          lg;
        bit          we;
        bit          err_e;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [2:0]  op;
        wi = if_req && (!ls_req || starve == SL);
        @(negedge clk);
        check("if_gnt", 32'(if_gnt), 32'(wi));
        check("ls_gnt", 32'(ls_gnt), 32'(!wi));
        if (wi)
            starve = 0;
        else if (if_req && starve < SL)
            starve++;
        we = wi ? 1'b0 : ls_we;
        a  = wi ? if_addr : ls_addr;
        op = wi ? 3'd2 : ls_op;
        wd = ls_wdata;
        lg = is_legal(we, a, op);
        err_e = 1'b1;
        exp_rd = '0;
        @(posedge clk); #1;
        if (wi) if_req = 1'b0;
        else ls_req = 1'b0;
        if (lg) begin
            for (int k = 1; k <= TO; k++) begin
                if (k == d) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
                @(negedge clk);
                check("mem_req_wait", 32'(mem_req), 32'd1);
                check("mem_we", 32'(mem_we), 32'(we));
                check("mem_addr", mem_addr, a);
                check("mem_op", 32'(mem_op), 32'(op));
                if (!wi) check("mem_wdata", mem_wdata, wd);
                check("gnt_busy", 32'(if_gnt | ls_gnt), 32'd0);
                check("rvalid_busy", 32'(if_rvalid | ls_rvalid), 32'd0);
                @(posedge clk); #1;
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                if (k == d) begin
                    err_e = 1'b0;
                    exp_rd = we ? 32'd0 : rd;
                    break;
                end
            end
        end
        @(negedge clk);
        check("mem_req_resp", 32'(mem_req), 32'd0);
        check("gnt_resp", 32'(if_gnt | ls_gnt), 32'd0);
        check("if_rvalid", 32'(if_rvalid), 32'(wi));
        check("ls_rvalid", 32'(ls_rvalid), 32'(!wi));
        check("if_rdata", if_rdata, wi ? exp_rd : 32'd0);
        check("ls_rdata", ls_rdata, wi ? 32'd0 : exp_rd);
        check("if_err", 32'(if_err), 32'(wi && err_e));
        check("ls_err", 32'(ls_err), 32'(!wi && err_e));
        @(posedge clk); #1;
        won_if = wi;
    endtask

    task automatic set_ls(input bit we, input logic [31:0] a,
                          input logic [2:0] op, input logic [31:0] wd);
        ls_req = 1'b1;
        ls_we = we;
        ls_addr = a;
        ls_op = op;
        ls_wdata = wd;
    endtask

    task automatic idle_cycle();
        if_req = 1'b0;
        ls_req = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [2:0] op_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    initial begin
        bit w;
        int d;
        int idx;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_gnt", 32'(if_gnt | ls_gnt), 32'd0);
        check("rst_rvalid", 32'(if_rvalid | ls_rvalid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Both held continuously: IFU wins every fifth grant.
        for (int i = 0; i < 10; i++) begin
            if_req = 1'b1;
            if_addr = 32'h0000_1000 + 32'(i * 4);
            set_ls(1'b0, 32'h8000_0000 + 32'(i * 4), 3'd2, 32'd0);
            run_txn(1, $urandom, w);
            check("starve_order", 32'(w), 32'(i == 4 || i == 9));
        end
        idle_cycle();

        set_ls(1'b0, 32'h8000_0004, 3'd2, 32'd0);
        run_txn(3, 32'hDEAD_BEEF, w);

        set_ls(1'b1, 32'h8000_0002, 3'd2, 32'h1111_2222);
        run_txn(1, 32'h5, w);
        set_ls(1'b0, 32'h8000_0003, 3'd1, 32'd0);
        run_txn(1, 32'h6, w);
        set_ls(1'b0, 32'h8000_0001, 3'd1, 32'd0);
        run_txn(2, 32'h0000_BEEF, w);
        set_ls(1'b1, 32'h8000_0000, 3'd4, 32'd0);
        run_txn(1, 32'h7, w);

        set_ls(1'b0, 32'h0000_0040, 3'd2, 32'd0);
        run_txn(0, 32'h0, w);
        set_ls(1'b0, 32'h0000_0044, 3'd2, 32'd0);
        run_txn(TO, 32'hCAFE_F00D, w);

        set_ls(1'b1, 32'h0000_0010, 3'd0, 32'h1234_56AB);
        run_txn(2, 32'hFFFF_FFFF, w);

        // Reset while waiting on memory.
        set_ls(1'b0, 32'h0000_0080, 3'd2, 32'd0);
        @(negedge clk);
        check("rw_gnt", 32'(ls_gnt), 32'd1);
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        check("rw_mem_req_before", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1 check("rw_mem_req_async", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        starve = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rw_no_rvalid", 32'(if_rvalid | ls_rvalid), 32'd0);
            @(posedge clk); #1;
        end
        set_ls(1'b0, 32'h0000_0084, 3'd2, 32'd0);
        run_txn(2, 32'h0BAD_F00D, w);

        repeat (200) begin
            if (!if_req) begin
                if_req = 1'($urandom_range(0, 1));
                if_addr = $urandom;
                if ($urandom_range(0, 5) != 0) if_addr[1:0] = 2'b00;
            end
            if (!ls_req) begin
                ls_req = 1'($urandom_range(0, 1));
                ls_we = 1'($urandom_range(0, 1));
                idx = $urandom_range(0, 10);
                ls_op = (idx > 7) ? 3'd2 : op_tab[idx];
                ls_addr = $urandom;
                if ($urandom_range(0, 2) != 0) ls_addr[1:0] = 2'b00;
                ls_wdata = $urandom;
            end
            if (!if_req && !ls_req) ls_req = 1'b1;
            d = $urandom_range(1, TO + 2);
            if (d > TO) d = 0;
            run_txn(d, $urandom, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
